// File: rtl/log2_pkg.sv
// Shared constants and the elaboration-time generator for the log2 mantissa
// lookup tables used by log2_lut_pipe.
package log2_pkg;

    // Rounding mode carried with each beat (in_floor).
    localparam logic MODE_ROUND = 1'b0;
    localparam logic MODE_FLOOR = 1'b1;

    // Fraction bits of the fixed-point working value used while generating
    // the tables; wide enough that truncation error never reaches an
    // output-bit boundary for practical widths.
    localparam int FIX_BITS = 62;

    // Returns floor(x) (floor_mode=1) or floor(x+0.5) (floor_mode=0) where
    // x = log2(1 + f/2^in_w) * 2^(out_w-1).
    // The log2 fraction bits are produced by repeated squaring of the
    // mantissa: each squaring doubles the log, and the mantissa reaching 2.0
    // yields a 1 bit. out_w bits are produced, one more than the output
    // fraction, so that round-half-up is (y+1)>>1 and floor is y>>1.
    function automatic int log2_entry(input int in_w, input int out_w,
                                      input int f, input logic floor_mode);
        logic [127:0] v;
        int           y;
        v = (128'(f) + (128'(1) << in_w)) << (FIX_BITS - in_w);
        y = 0;
        for (int i = 0; i < out_w; i++) begin
            v = (v * v) >> FIX_BITS;
            y = y << 1;
            if (v[127:FIX_BITS+1] != '0) begin
                y = y | 1;
                v = v >> 1;
            end
        end
        if (floor_mode == MODE_FLOOR) begin
            return y >> 1;
        end
        return (y + 1) >> 1;
    endfunction

endpackage

// File: rtl/log2_lut_rom.sv
// One lane of the log2 lookup: a constant table per rounding mode, built at
// elaboration, selected by the beat's mode bit. Purely combinational.
module log2_lut_rom
    import log2_pkg::*;
#(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 5
) (
    input  logic [IN_WIDTH-1:0]  idx,
    input  logic                 floor_mode,
    output logic [OUT_WIDTH-1:0] val
);

    localparam int DEPTH = 1 << IN_WIDTH;

    logic [OUT_WIDTH-1:0] round_tbl [DEPTH];
    logic [OUT_WIDTH-1:0] floor_tbl [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        localparam int RV = log2_entry(IN_WIDTH, OUT_WIDTH, i, MODE_ROUND);
        localparam int FV = log2_entry(IN_WIDTH, OUT_WIDTH, i, MODE_FLOOR);
        assign round_tbl[i] = OUT_WIDTH'(RV);
        assign floor_tbl[i] = OUT_WIDTH'(FV);
    end

    assign val = (floor_mode == MODE_FLOOR) ? floor_tbl[idx] : round_tbl[idx];

endmodule

// File: rtl/log2_lut_pipe.sv
// Two-stage pipelined log2 mantissa lookup with LANES parallel lanes sharing
// one valid/ready handshake and an opaque tag carried alongside each beat.
//
// Handshake: a beat transfers on any rising edge where valid && ready are
// both high. in_ready never looks at in_valid. Once out_valid rises, out_log,
// out_tag and out_valid hold unchanged until a cycle with out_ready high.
module log2_lut_pipe #(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 5,
    parameter int LANES     = 1,
    parameter int TAG_WIDTH = 4
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*IN_WIDTH-1:0]      in_frac,
    input  logic                           in_floor,
    input  logic [TAG_WIDTH-1:0]           in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*OUT_WIDTH-1:0]     out_log,
    output logic [TAG_WIDTH-1:0]           out_tag
);

    // Stage 1: captured input beat
    logic                          s1_valid;
    logic [LANES*IN_WIDTH-1:0]     s1_frac;
    logic                          s1_floor;
    logic [TAG_WIDTH-1:0]          s1_tag;

    // Stage 2: looked-up result
    logic                          s2_valid;
    logic [LANES*OUT_WIDTH-1:0]    s2_log;
    logic [TAG_WIDTH-1:0]          s2_tag;

    logic [LANES*OUT_WIDTH-1:0]    lut_log;
    logic                          s2_adv;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || !s2_valid || out_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        log2_lut_rom #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_rom (
            .idx        (s1_frac[l*IN_WIDTH +: IN_WIDTH]),
            .floor_mode (s1_floor),
            .val        (lut_log[l*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    // Occupancy flags: cleared by reset, which discards any in-flight beats.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Data and tag registers: unreset, only loaded when a beat moves in.
    always_ff @(posedge clock) begin
        if (in_ready && in_valid) begin
            s1_frac  <= in_frac;
            s1_floor <= in_floor;
            s1_tag   <= in_tag;
        end
        if (s2_adv && s1_valid) begin
            s2_log <= lut_log;
            s2_tag <= s1_tag;
        end
    end

    assign out_valid = s2_valid;
    assign out_log   = s2_log;
    assign out_tag   = s2_tag;

endmodule
